// File: rtl/rom_burst_reader.sv
// Burst sequencer in front of a registered-read lookup ROM: streams `length`
// consecutive words from `base_addr` (wrapping) onto a valid/ready stream.
module rom_burst_reader #(
    parameter int width      = 8,
    parameter int depth      = 256,
    parameter int addr_width = $clog2(depth),
    parameter int len_width  = addr_width + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [len_width-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] rom_addr,
    output logic                  rom_read,
    input  logic [width-1:0]      rom_data,
    output logic [width-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   next_addr_q, next_addr_d;
    logic [len_width-1:0]    issue_cnt_q, issue_cnt_d;
    logic [len_width-1:0]    recv_cnt_q, recv_cnt_d;
    logic                    inflight_q, inflight_d;

    // Two-entry capture buffer: data and end-of-burst flag per slot
    logic [1:0][width-1:0]   buf_data_q, buf_data_d;
    logic [1:0]              buf_last_q, buf_last_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop;
    logic                    push;
    logic                    issue;
    logic [2:0]              pending;
    logic [addr_width-1:0]   addr_inc;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_last  = out_valid & buf_last_q[rd_ptr_q];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign rom_addr  = next_addr_q;
    assign rom_read  = issue;

    assign pop  = out_valid & out_ready;
    assign push = inflight_q;

    // Words buffered plus the one in flight, minus the one leaving this cycle,
    // must leave room for the word a new read would return next cycle.
    assign pending  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue    = (state_q == S_RUN) && (issue_cnt_q != '0) && (pending < 3'd2);
    assign addr_inc = (next_addr_q == LAST_ADDR) ? '0 : next_addr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        inflight_d  = issue;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        next_addr_d = base_addr;
                        issue_cnt_d = length;
                        recv_cnt_d  = length;
                        state_d     = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    next_addr_d = addr_inc;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                end
                if (pop && out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            buf_data_d[wr_ptr_q] = rom_data;
            buf_last_d[wr_ptr_q] = (recv_cnt_q == len_width'(1));
            wr_ptr_d             = ~wr_ptr_q;
            recv_cnt_d           = recv_cnt_q - 1'b1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            inflight_q  <= inflight_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule
